uart_tx_sched: RTL and testbench

//  Message-level round-robin scheduler sharing one uart_tx_dfs transmitter among NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_sched.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - message-level round-robin scheduler sharing one UART transmitter
// A requester owns the transmitter for a whole message; bytes are paced on the done edge.
module uart_tx_sched #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 16,
    parameter int TIMEOUT_CLKS = 65536
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Busy,
    output logic                 o_Error,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    input  logic                 i_TX_Active,
    input  logic                 i_TX_Done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOAD      = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    logic [1:0]         r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_gidx;
    logic               r_last;
    logic [TW-1:0]      r_tmo;
    logic [GW-1:0]      r_gap;
    logic               r_done_prev;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_busy;
    logic               r_err;
    logic               r_dv;
    logic [7:0]         r_byte;

    logic               w_done_rise;
    logic               w_pick_vld;
    logic [PW-1:0]      w_pick_idx;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic [PW:0]        w_sum;
    logic [PW-1:0]      w_cand;
    logic [PW-1:0]      w_ptr_next;
    logic [7:0]         w_sel_byte;

    assign w_done_rise = i_TX_Done & ~r_done_prev;
    assign w_pick_oh   = NUM_REQ'(1) << w_pick_idx;
    assign w_ptr_next  = (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
    assign w_sel_byte  = i_Req_Byte[{r_gidx, 3'b000} +: 8];

    // Scan offsets from the highest down so the nearest requester at or above the pointer wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_sum      = '0;
        w_cand     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PW+1)'(NUM_REQ);
            end
            w_cand = w_sum[PW-1:0];
            if (i_Req[w_cand]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_cand;
            end
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_last      <= 1'b0;
            r_tmo       <= '0;
            r_gap       <= '0;
            r_done_prev <= 1'b0;
            r_grant     <= '0;
            r_ack       <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_dv        <= 1'b0;
            r_byte      <= '0;
        end else begin
            r_done_prev <= i_TX_Done;
            r_dv        <= 1'b0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_vld && !i_TX_Active) begin
                        r_grant <= w_pick_oh;
                        r_gidx  <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_dv    <= 1'b1;
                    r_byte  <= w_sel_byte;
                    r_ack   <= r_grant;
                    r_last  <= i_Req_Last[r_gidx];
                    r_tmo   <= '0;
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // A done edge in the same clock as the timeout takes precedence.
                    if (w_done_rise) begin
                        if (!r_last && i_Req[r_gidx]) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_err   <= ~r_last;
                            r_ptr   <= w_ptr_next;
                            r_grant <= '0;
                            r_gap   <= '0;
                            r_state <= S_GAP;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_ptr   <= w_ptr_next;
                        r_grant <= '0;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Req_Ack = r_ack;
    assign o_Grant   = r_grant;
    assign o_Busy    = r_busy;
    assign o_Error   = r_err;
    assign o_TX_DV   = r_dv;
    assign o_TX_Byte = r_byte;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched with a behavioural 8N1 transmitter
module tb_uart_tx_sched;
    localparam int N   = 4;
    localparam int GAP = 4;
    localparam int TMO = 100;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   req_last = '0;
    logic [8*N-1:0] req_byte = '0;
    logic [N-1:0]   ack, grant;
    logic           busy, err, tx_dv;
    logic [7:0]     tx_byte;
    logic           u_active, u_done;

    uart_tx_sched #(.NUM_REQ(N), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TMO)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Req(req), .i_Req_Byte(req_byte), .i_Req_Last(req_last),
        .o_Req_Ack(ack), .o_Grant(grant), .o_Busy(busy), .o_Error(err),
        .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .i_TX_Active(u_active), .i_TX_Done(u_done)
    );

    always #5 clk = ~clk;

    // Transmitter stand-in: CLKS_PER_BIT=8, 10-bit frame, done held 3 clocks; stub mode ignores DV.
    bit       u_stub = 1'b0;
    logic     u_busy;
    logic [2:0] u_cnt;
    logic [3:0] u_bit;
    logic [1:0] u_dh;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            u_busy <= 1'b0; u_active <= 1'b0; u_done <= 1'b0;
            u_cnt <= '0; u_bit <= '0; u_dh <= '0;
        end else if (!u_stub && tx_dv && !u_busy) begin
            u_busy <= 1'b1; u_active <= 1'b1; u_done <= 1'b0;
            u_cnt <= '0; u_bit <= '0; u_dh <= '0;
        end else if (u_busy) begin
            if (u_cnt == 3'd7) begin
                u_cnt <= '0;
                if (u_bit == 4'd9) begin
                    u_busy <= 1'b0; u_active <= 1'b0; u_done <= 1'b1; u_dh <= 2'd3;
                end else begin
                    u_bit <= u_bit + 1'b1;
                end
            end else begin
                u_cnt <= u_cnt + 1'b1;
            end
        end else if (u_dh != 2'd0) begin
            u_dh <= u_dh - 1'b1;
            if (u_dh == 2'd1) u_done <= 1'b0;
        end
    end

    int vectors = 0, miscompares = 0;
    int cyc = 0, ack_cnt = 0, last_rise = -1, m_ptr = 0;
    logic prev_done = 1'b0;
    logic [N-1:0] en = '1;
    logic [7:0] qb[N][$];
    logic       ql[N][$];
    logic [7:0] mb[N][$];
    logic       ml[N][$];
    int         log_g[$];
    logic [7:0] log_b[$];
    int         log_t[$];
    int         err_t[$];
    int         exp_g[$];
    logic [7:0] exp_b[$];

    typedef struct { logic [N-1:0] mask; int exp_idx; } arb_vec_t;
    arb_vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        int idx = -1, cnt = 0;
        for (int k = 0; k < N; k++) if (v[k]) begin idx = k; cnt++; end
        return (cnt == 1) ? idx : -1;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req[k]            = en[k] && (qb[k].size() > 0);
            req_byte[8*k +: 8] = (qb[k].size() > 0) ? qb[k][0] : 8'h00;
            req_last[k]       = (ql[k].size() > 0) ? ql[k][0] : 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (tx_dv) begin log_g.push_back(oh2idx(grant)); log_b.push_back(tx_byte); log_t.push_back(cyc); end
        if (err) err_t.push_back(cyc);
        if (u_done && !prev_done) last_rise = cyc;
        prev_done = u_done;
        for (int k = 0; k < N; k++) begin
            if (ack[k]) begin
                ack_cnt++;
                if (qb[k].size() > 0) begin qb[k].delete(0); ql[k].delete(0); end
            end
        end
        drive();
    endtask

    task automatic push_byte(input int k, input logic [7:0] b, input logic l);
        qb[k].push_back(b); ql[k].push_back(l);
        mb[k].push_back(b); ml[k].push_back(l);
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin mb[k].delete(); ml[k].delete(); end
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (qb[k].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // Whole-message round robin over the queued messages, starting from the model pointer.
    task automatic model_run();
        int g;
        logic l;
        exp_g.delete(); exp_b.delete();
        while (1) begin
            g = -1;
            for (int i = 0; i < N; i++) if (g < 0 && mb[(m_ptr + i) % N].size() > 0) g = (m_ptr + i) % N;
            if (g < 0) break;
            do begin
                exp_g.push_back(g); exp_b.push_back(mb[g][0]);
                l = ml[g][0];
                mb[g].delete(0); ml[g].delete(0);
            end while (!l && mb[g].size() > 0);
            m_ptr = (g + 1) % N;
        end
    endtask

    task automatic wait_dv(input int target, input int bound, input string name);
        bit ok = 1'b0;
        for (int t = 0; t < bound; t++) begin
            if (log_b.size() >= target) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) ok = (log_b.size() >= target);
        check({name, " dv wait"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_err(input int target, input int bound, input string name);
        bit ok = 1'b0;
        for (int t = 0; t < bound; t++) begin
            if (err_t.size() >= target) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) ok = (err_t.size() >= target);
        check({name, " err wait"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int bound, input string name);
        bit ok = 1'b0;
        for (int t = 0; t < bound; t++) begin
            tick();
            if (!busy) begin ok = 1'b1; break; end
        end
        check({name, " idle wait"}, 32'(ok), 32'd1);
    endtask

    task automatic run_batch(input string name);
        int a0, e0, n0;
        bit ok;
        model_run();
        a0 = ack_cnt; e0 = err_t.size(); n0 = log_b.size();
        drive();
        ok = 1'b0;
        for (int t = 0; t < 200 * exp_b.size() + 100; t++) begin
            tick();
            if (t > 2 && all_empty() && !busy) begin ok = 1'b1; break; end
        end
        check({name, " done"}, 32'(ok), 32'd1);
        check({name, " dv count"}, 32'(log_b.size() - n0), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size(); i++) begin
            if (n0 + i < log_b.size())
                check({name, " grant/byte"}, 32'(log_g[n0+i] * 256 + log_b[n0+i]), 32'(exp_g[i] * 256 + exp_b[i]));
        end
        check({name, " acks"}, 32'(ack_cnt - a0), 32'(exp_b.size()));
        check({name, " errors"}, 32'(err_t.size() - e0), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, e0, a0, lat, d, g;
        tbl[0] = '{4'b1111, 0}; tbl[1] = '{4'b1111, 1}; tbl[2] = '{4'b0001, 0};
        tbl[3] = '{4'b1000, 3}; tbl[4] = '{4'b0110, 1}; tbl[5] = '{4'b0011, 0};
        tbl[6] = '{4'b1100, 2}; tbl[7] = '{4'b0101, 0}; tbl[8] = '{4'b1010, 1};

        drive();
        repeat (3) tick();
        check("reset grant", 32'(grant), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset dv", 32'(tx_dv), 32'd0);
        check("reset ack", 32'(ack), 32'd0);
        check("reset error", 32'(err), 32'd0);
        check("reset byte", 32'(tx_byte), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Single-byte messages: grant choice, latency, ack, pointer rotation and wrap.
        for (int v = 0; v < 9; v++) begin
            for (int k = 0; k < N; k++) if (tbl[v].mask[k]) push_byte(k, 8'(16 * v + k), 1'b1);
            clear_model();
            drive();
            n0 = log_b.size();
            lat = 0;
            for (int t = 1; t <= 20; t++) begin
                tick();
                if (log_b.size() > n0) begin lat = t; break; end
            end
            check("arb latency", 32'(lat), 32'd2);
            if (log_b.size() > n0) begin
                check("arb grant", 32'(log_g[n0]), 32'(tbl[v].exp_idx));
                check("arb byte", 32'(log_b[n0]), 32'(16 * v + tbl[v].exp_idx));
            end
            check("arb ack", 32'(ack), 32'(1 << tbl[v].exp_idx));
            for (int k = 0; k < N; k++) if (k != tbl[v].exp_idx) begin qb[k].delete(); ql[k].delete(); end
            drive();
            wait_idle(300, "arb");
            m_ptr = (tbl[v].exp_idx + 1) % N;
        end

        push_byte(0, 8'h55, 1'b0); push_byte(0, 8'hA3, 1'b0); push_byte(0, 8'h0F, 1'b1);
        run_batch("t1 three-byte");

        for (int i = 0; i < 3; i++) begin
            push_byte(1, 8'(8'h20 + i), 1'b1);
            push_byte(3, 8'(8'h30 + i), 1'b1);
        end
        run_batch("t2 alternate");
        push_byte(0, 8'hC0, 1'b1); push_byte(1, 8'hC1, 1'b1);
        run_batch("t2 wrap");

        // Late requester waits for message end plus the gap.
        n0 = log_b.size();
        push_byte(0, 8'h31, 1'b0); push_byte(0, 8'h32, 1'b0); push_byte(0, 8'h33, 1'b1);
        clear_model(); drive();
        wait_dv(n0 + 2, 400, "t3 second");
        push_byte(2, 8'h44, 1'b1); clear_model(); drive();
        d = -1000; g = -1;
        for (int t = 0; t < 400; t++) begin
            tick();
            if (d < 0 && log_b.size() >= n0 + 3 && last_rise > log_t[n0+2]) d = last_rise;
            if (grant[2] && g < 0) begin g = cyc; break; end
        end
        check("t3 gap latency", 32'(g - d), 32'd6);
        wait_idle(300, "t3");
        if (log_b.size() >= n0 + 4) check("t3 late byte", 32'(log_g[n0+3] * 256 + log_b[n0+3]), 32'h244);
        m_ptr = 3;

        // Transmitter that never finishes: both pending messages time out in order.
        u_stub = 1'b1;
        n0 = log_b.size(); e0 = err_t.size();
        push_byte(0, 8'h51, 1'b1); push_byte(1, 8'h52, 1'b1); clear_model(); drive();
        wait_dv(n0 + 1, 20, "t4 first");
        wait_err(e0 + 1, 200, "t4 timeout");
        if (log_b.size() > n0 && err_t.size() > e0) begin
            check("t4 first grant", 32'(log_g[n0]), 32'd0);
            check("t4 timeout latency", 32'(err_t[e0] - log_t[n0]), 32'(TMO));
            check("t4 grant released", 32'(grant), 32'd0);
        end
        wait_dv(n0 + 2, 30, "t4 next");
        if (log_b.size() > n0 + 1) check("t4 next grant", 32'(log_g[n0+1]), 32'd1);
        wait_err(e0 + 2, 200, "t4 second timeout");
        u_stub = 1'b0;
        wait_idle(50, "t4");
        check("t4 error count", 32'(err_t.size() - e0), 32'd2);
        m_ptr = 2;

        // Requester drops mid-message.
        n0 = log_b.size(); e0 = err_t.size();
        push_byte(0, 8'h61, 1'b0); push_byte(0, 8'h62, 1'b1); clear_model(); drive();
        wait_dv(n0 + 1, 20, "t5 first");
        en[0] = 1'b0; drive();
        wait_err(e0 + 1, 200, "t5 drop");
        if (err_t.size() > e0) check("t5 error on done rise", 32'(err_t[e0] - last_rise), 32'd1);
        wait_idle(50, "t5");
        check("t5 no second dv", 32'(log_b.size() - n0), 32'd1);
        en[0] = 1'b1; qb[0].delete(); ql[0].delete(); drive();
        m_ptr = 1;
        push_byte(0, 8'h71, 1'b1); push_byte(1, 8'h72, 1'b1);
        run_batch("t5 pointer");

        // Reset in the middle of the second byte's data bits.
        n0 = log_b.size();
        push_byte(0, 8'h81, 1'b0); push_byte(0, 8'h82, 1'b0); push_byte(0, 8'h83, 1'b1);
        clear_model(); drive();
        wait_dv(n0 + 2, 300, "t6 second");
        repeat (30) tick();
        rst = 1'b1;
        #1;
        check("t6 reset grant", 32'(grant), 32'd0);
        check("t6 reset busy", 32'(busy), 32'd0);
        check("t6 reset ack", 32'(ack), 32'd0);
        for (int k = 0; k < N; k++) begin qb[k].delete(); ql[k].delete(); end
        drive();
        repeat (3) tick();
        a0 = ack_cnt;
        rst = 1'b0;
        repeat (3) tick();
        check("t6 no spurious ack", 32'(ack_cnt - a0), 32'd0);
        check("t6 idle after reset", 32'(busy), 32'd0);
        m_ptr = 0;
        push_byte(0, 8'h91, 1'b0); push_byte(0, 8'h92, 1'b1);
        run_batch("t6 restart");

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) begin
                int nm = $urandom_range(0, 2);
                for (int m = 0; m < nm; m++) begin
                    int len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) push_byte(k, 8'($urandom), (b == len - 1));
                end
            end
            run_batch("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
